// File: rtl/zxw_cpu_pkg.sv
// Shared definitions for the zxw accumulator CPU: opcodes, FSM states, instruction-field helpers.
// Latency: none (package only).
// Backpressure: none.
package zxw_cpu_pkg;

   // Widest instruction word the field helpers accept (4-bit opcode + up to 32-bit immediate).
   localparam int unsigned INSTR_MAX_W = 36;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_XOR  = 4'h6;
   localparam logic [3:0] OP_INSW = 4'h7;
   localparam logic [3:0] OP_INPB = 4'h8;
   localparam logic [3:0] OP_OUTH = 4'h9;
   localparam logic [3:0] OP_OUTL = 4'hA;
   localparam logic [3:0] OP_JMP  = 4'hB;
   localparam logic [3:0] OP_JZ   = 4'hC;
   localparam logic [3:0] OP_JC   = 4'hD;
   localparam logic [3:0] OP_SHL  = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_EXEC   = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   // Opcode sits directly above the immediate field.
   function automatic logic [3:0] ir_op(input logic [INSTR_MAX_W-1:0] word,
                                        input int unsigned data_w);
      logic [INSTR_MAX_W-1:0] sh;
      sh = word >> data_w;
      return sh[3:0];
   endfunction

   // Z tracks the accumulator only for instructions that produce a new A value.
   function automatic logic op_sets_z(input logic [3:0] op);
      return ((op >= OP_LDI) && (op <= OP_INPB)) || (op == OP_SHL);
   endfunction

endpackage

// File: rtl/zxw_prog_ram.sv
// Program store: one write port, one registered read port; read data doubles as the CPU's IR.
// Latency: write lands at the edge; read data valid one edge after re is sampled.
// Backpressure: none; the caller gates we/re.
//   clk/rst      : clock, synchronous active-high reset (clears read register only)
//   we/waddr/wdata : write port
//   re/raddr/rdata : registered read port
module zxw_prog_ram #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

   // Memory contents survive reset; only the output register is cleared.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/zxw_cpu3_param.sv
// Parametrised accumulator CPU with writable program RAM and two display registers.
// Latency: Run registered on entry; instruction i executes 3+2i edges after Run is sampled.
// Backpressure: none; program writes are dropped while FETCH/EXEC are active.
//   Clock, Reset           : clock, synchronous active-high reset
//   Run                    : start level (IDLE->run, HALTED->IDLE when low)
//   SW_in, PB_in           : input ports read by INSW/INPB
//   Prog_we/addr/data      : program load port {opcode, imm}
//   DHR_out, DLR_out       : display registers written by OUTH/OUTL
//   Halted, Busy           : status
module zxw_cpu3_param
   import zxw_cpu_pkg::*;
#(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Run,
   input  logic [DATA_W-1:0] SW_in,
   input  logic [DATA_W-1:0] PB_in,
   input  logic              Prog_we,
   input  logic [ADDR_W-1:0] Prog_addr,
   input  logic [DATA_W+3:0] Prog_data,
   output logic [DATA_W-1:0] DHR_out,
   output logic [DATA_W-1:0] DLR_out,
   output logic              Halted,
   output logic              Busy
);

   generate
      if (ADDR_W > DATA_W) begin : g_bad_params
         $error("zxw_cpu3_param: ADDR_W must not exceed DATA_W (jump target comes from imm)");
      end
   endgenerate

   state_t              state, state_nxt;
   logic                run_q;
   logic [ADDR_W-1:0]   pc;
   logic [DATA_W-1:0]   a, a_nxt;
   logic                c, c_nxt, z;
   logic                jump;
   logic [DATA_W+3:0]   ir;
   logic [3:0]          op;
   logic [DATA_W-1:0]   imm;
   logic                ram_we;

   // Writes only while the core is parked; a coincident Reset blocks them too.
   assign ram_we = Prog_we && !Reset && ((state == ST_IDLE) || (state == ST_HALTED));

   zxw_prog_ram #(.WIDTH(DATA_W + 4), .ADDR_W(ADDR_W)) u_ram (
      .clk   (Clock),
      .rst   (Reset),
      .we    (ram_we),
      .waddr (Prog_addr),
      .wdata (Prog_data),
      .re    (state == ST_FETCH),
      .raddr (pc),
      .rdata (ir)
   );

   assign op  = ir_op(INSTR_MAX_W'(ir), DATA_W);
   assign imm = ir[DATA_W-1:0];

   assign Halted = (state == ST_HALTED);
   assign Busy   = (state == ST_FETCH) || (state == ST_EXEC);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (run_q) state_nxt = ST_FETCH;
         ST_FETCH:  state_nxt = ST_EXEC;
         ST_EXEC:   state_nxt = (op == OP_HALT) ? ST_HALTED : ST_FETCH;
         ST_HALTED: if (!run_q) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Inline ALU and branch decision for the instruction held in IR.
   always_comb begin
      a_nxt = a;
      c_nxt = c;
      jump  = 1'b0;
      case (op)
         OP_LDI:  a_nxt = imm;
         OP_ADD:  {c_nxt, a_nxt} = {1'b0, a} + {1'b0, imm};
         OP_SUB:  begin
                     a_nxt = a - imm;
                     c_nxt = (a < imm);
                  end
         OP_AND:  a_nxt = a & imm;
         OP_OR:   a_nxt = a | imm;
         OP_XOR:  a_nxt = a ^ imm;
         OP_INSW: a_nxt = SW_in;
         OP_INPB: a_nxt = PB_in;
         OP_JMP:  jump  = 1'b1;
         OP_JZ:   jump  = z;
         OP_JC:   jump  = c;
         OP_SHL:  {c_nxt, a_nxt} = {a, 1'b0};
         default: ;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state   <= ST_IDLE;
         run_q   <= 1'b0;
         pc      <= '0;
         a       <= '0;
         c       <= 1'b0;
         z       <= 1'b0;
         DHR_out <= '0;
         DLR_out <= '0;
      end else begin
         state <= state_nxt;
         run_q <= Run;
         if ((state == ST_IDLE) && run_q) pc <= '0;
         if (state == ST_EXEC) begin
            a <= a_nxt;
            c <= c_nxt;
            if (op_sets_z(op)) z <= (a_nxt == '0);
            if (op == OP_OUTH) DHR_out <= a;
            if (op == OP_OUTL) DLR_out <= a;
            if (op != OP_HALT) pc <= jump ? imm[ADDR_W-1:0] : pc + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_zxw_cpu3_param.sv
// Directed bench for zxw_cpu3_param: 4-bit build plus an 8-bit/32-word build.
// Latency: edge-exact checks against the 3+2i execution schedule.
// Backpressure: n/a.
module tb_zxw_cpu3_param;

   logic        Clock;
   logic        Reset;
   logic        Run;
   logic [3:0]  SW_in, PB_in;
   logic        Prog_we;
   logic [3:0]  Prog_addr;
   logic [7:0]  Prog_data;
   logic [3:0]  DHR_out, DLR_out;
   logic        Halted, Busy;

   logic        Run8;
   logic [7:0]  SW8, PB8;
   logic        Prog_we8;
   logic [4:0]  Prog_addr8;
   logic [11:0] Prog_data8;
   logic [7:0]  DHR8, DLR8;
   logic        Halted8, Busy8;

   int n_chk  = 0;
   int n_pass = 0;

   logic [7:0]  prog [$];
   logic [11:0] prog8 [$];

   zxw_cpu3_param #(.DATA_W(4), .ADDR_W(4)) u_dut (
      .Clock(Clock), .Reset(Reset), .Run(Run), .SW_in(SW_in), .PB_in(PB_in),
      .Prog_we(Prog_we), .Prog_addr(Prog_addr), .Prog_data(Prog_data),
      .DHR_out(DHR_out), .DLR_out(DLR_out), .Halted(Halted), .Busy(Busy)
   );

   zxw_cpu3_param #(.DATA_W(8), .ADDR_W(5)) u_dut8 (
      .Clock(Clock), .Reset(Reset), .Run(Run8), .SW_in(SW8), .PB_in(PB8),
      .Prog_we(Prog_we8), .Prog_addr(Prog_addr8), .Prog_data(Prog_data8),
      .DHR_out(DHR8), .DLR_out(DLR8), .Halted(Halted8), .Busy(Busy8)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge Clock);
   endtask

   task automatic do_reset();
      Reset   = 1'b1;
      Run     = 1'b0;
      Prog_we = 1'b0;
      step(2);
      Reset   = 1'b0;
   endtask

   task automatic load_prog();
      foreach (prog[i]) begin
         Prog_we   = 1'b1;
         Prog_addr = 4'(i);
         Prog_data = prog[i];
         step(1);
      end
      Prog_we = 1'b0;
   endtask

   task automatic run_until_halt(input string tag, input int budget);
      int k;
      k = 0;
      while (!Halted && k < budget) begin
         step(1);
         k++;
      end
      check({tag, "_halted"}, 32'(Halted), 32'd1);
   endtask

   task automatic stop_run(input string tag);
      int k;
      Run = 1'b0;
      k = 0;
      while ((Halted || Busy) && k < 20) begin
         step(1);
         k++;
      end
      check({tag, "_idle"}, 32'(Halted | Busy), 32'd0);
   endtask

   initial begin
      Reset = 1'b1; Run = 1'b0; SW_in = 4'h0; PB_in = 4'h0;
      Prog_we = 1'b0; Prog_addr = '0; Prog_data = '0;
      Run8 = 1'b0; SW8 = '0; PB8 = '0; Prog_we8 = 1'b0; Prog_addr8 = '0; Prog_data8 = '0;
      step(2);
      Reset = 1'b0;
      step(1);

      check("rst_dhr",    32'(DHR_out), 32'h0);
      check("rst_dlr",    32'(DLR_out), 32'h0);
      check("rst_halted", 32'(Halted),  32'h0);
      check("rst_busy",   32'(Busy),    32'h0);
      check("rst8_dhr",   32'(DHR8),    32'h0);

      // 1: LDI 5, OUTH, ADD 3, OUTL, HALT -- edge-exact schedule
      prog = '{8'h15, 8'h90, 8'h23, 8'hA0, 8'hF0};
      load_prog();
      Run = 1'b1;
      step(5);
      check("t1_dhr_e4",  32'(DHR_out), 32'h0);
      check("t1_busy",    32'(Busy),    32'h1);
      step(1);
      check("t1_dhr_e5",  32'(DHR_out), 32'h5);
      step(3);
      check("t1_dlr_e8",  32'(DLR_out), 32'h0);
      step(1);
      check("t1_dlr_e9",  32'(DLR_out), 32'h8);
      step(1);
      check("t1_halt_e10", 32'(Halted), 32'h0);
      step(1);
      check("t1_halt_e11", 32'(Halted), 32'h1);
      check("t1_busy_end", 32'(Busy),   32'h0);
      stop_run("t1");

      // 2: carry + JC taken: 6 instructions, HALT at edge 13
      do_reset();
      prog = '{8'h1F, 8'h21, 8'hD4, 8'hA0, 8'h19, 8'h90, 8'hF0};
      load_prog();
      Run = 1'b1;
      step(13);
      check("t2_halt_e12", 32'(Halted), 32'h0);
      step(1);
      check("t2_halt_e13", 32'(Halted), 32'h1);
      check("t2_dhr",      32'(DHR_out), 32'h9);
      check("t2_dlr",      32'(DLR_out), 32'h0);
      stop_run("t2");

      // 4: IO ports
      SW_in = 4'hA; PB_in = 4'h6;
      prog = '{8'h70, 8'hA0, 8'h80, 8'h90, 8'hF0};
      load_prog();
      Run = 1'b1;
      run_until_halt("t4", 40);
      check("t4_dlr", 32'(DLR_out), 32'hA);
      check("t4_dhr", 32'(DHR_out), 32'h6);
      stop_run("t4");

      // 3: countdown loop, 11 instructions -> HALT at edge 23
      prog = '{8'h13, 8'h31, 8'hC4, 8'hB1, 8'hA0, 8'hF0};
      load_prog();
      Run = 1'b1;
      step(23);
      check("t3_halt_e22", 32'(Halted), 32'h0);
      step(1);
      check("t3_halt_e23", 32'(Halted), 32'h1);
      check("t3_dlr",      32'(DLR_out), 32'h0);
      stop_run("t3");

      // 3b: NOP fill, OUTH at 0, INSW at 15: second pass through 0 only after PC wraps
      prog = '{8'h90, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h70};
      load_prog();
      SW_in = 4'hC;
      Run = 1'b1;
      step(35);
      check("t3b_dhr_e34", 32'(DHR_out), 32'h0);
      step(1);
      check("t3b_dhr_e35", 32'(DHR_out), 32'hC);
      check("t3b_running", 32'(Halted),  32'h0);
      do_reset();

      // 5: program writes during FETCH/EXEC are ignored
      prog = '{8'h15, 8'h90, 8'h23, 8'hA0, 8'hF0};
      load_prog();
      Run = 1'b1;
      step(2);
      Prog_we = 1'b1; Prog_addr = 4'h1; Prog_data = 8'hA0;
      step(8);
      Prog_we = 1'b0;
      run_until_halt("t5", 20);
      check("t5_dhr", 32'(DHR_out), 32'h5);
      check("t5_dlr", 32'(DLR_out), 32'h8);
      stop_run("t5");

      // 6: reset at edge 6 aborts; RAM retained for re-run
      Run = 1'b1;
      step(6);
      check("t6_dhr_pre", 32'(DHR_out), 32'h5);
      Reset = 1'b1; Run = 1'b0;
      step(1);
      check("t6_dhr_rst",  32'(DHR_out), 32'h0);
      check("t6_dlr_rst",  32'(DLR_out), 32'h0);
      check("t6_halt_rst", 32'(Halted),  32'h0);
      check("t6_busy_rst", 32'(Busy),    32'h0);
      Reset = 1'b0;
      step(1);
      Run = 1'b1;
      run_until_halt("t6", 40);
      check("t6_dhr", 32'(DHR_out), 32'h5);
      check("t6_dlr", 32'(DLR_out), 32'h8);
      stop_run("t6");

      // Run and a write to address 0 on the same edge: the new word is fetched
      Run = 1'b1; Prog_we = 1'b1; Prog_addr = 4'h0; Prog_data = 8'h17;
      step(1);
      Prog_we = 1'b0;
      run_until_halt("tsim", 40);
      check("tsim_dhr", 32'(DHR_out), 32'h7);
      check("tsim_dlr", 32'(DLR_out), 32'hA);
      stop_run("tsim");

      // 7: 8-bit build, ADD FF carries out; JC proves C=1
      prog8 = '{12'h105, 12'h900, 12'h2FF, 12'hA00, 12'hD06, 12'hF00, 12'h900, 12'hF00};
      foreach (prog8[i]) begin
         Prog_we8 = 1'b1; Prog_addr8 = 5'(i); Prog_data8 = prog8[i];
         step(1);
      end
      Prog_we8 = 1'b0;
      Run8 = 1'b1;
      begin
         int k;
         k = 0;
         while (!Halted8 && k < 40) begin
            step(1);
            k++;
         end
      end
      check("t7_halted", 32'(Halted8), 32'h1);
      check("t7_dlr",    32'(DLR8),    32'h04);
      check("t7_dhr",    32'(DHR8),    32'h04);
      Run8 = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
